// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing with vblank-committed sprite position registers
// Counter decode is registered from the next-state values so every output lines up with DrawX/DrawY.

module vga_timing_gen #(
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 751,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 491,
  parameter int V_TOTAL      = 525,
  parameter int SPRITE_X0    = 316,
  parameter int SPRITE_Y0    = 232
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       upd_valid,
  input  logic [9:0] upd_x,
  input  logic [9:0] upd_y,
  output logic       upd_ready,
  output logic       pixel_clk,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [9:0] SpriteX,
  output logic [9:0] SpriteY
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SS     = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE     = 10'(H_SYNC_END);
  localparam logic [9:0] V_SS     = 10'(V_SYNC_START);
  localparam logic [9:0] V_SE     = 10'(V_SYNC_END);

  logic       pe;
  logic       line_end;
  logic       enter_frame;
  logic       enter_vblank;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       pend_full;
  logic [9:0] pend_x;
  logic [9:0] pend_y;

  assign pe           = pixel_clk;
  assign line_end     = pe && (DrawX == H_LAST);
  assign enter_frame  = line_end && (DrawY == V_LAST);
  assign enter_vblank = line_end && (DrawY == V_VIS_M1);
  assign upd_ready    = ~pend_full;
  assign sync         = 1'b0;

  always_comb begin
    x_nxt = DrawX;
    y_nxt = DrawY;
    if (pe) begin
      if (DrawX == H_LAST) begin
        x_nxt = '0;
        y_nxt = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
      end else begin
        x_nxt = DrawX + 10'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_clk    <= 1'b0;
      DrawX        <= '0;
      DrawY        <= '0;
      hs           <= 1'b1;
      vs           <= 1'b1;
      blank        <= 1'b1;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      pixel_clk    <= ~pixel_clk;
      DrawX        <= x_nxt;
      DrawY        <= y_nxt;
      hs           <= ~((x_nxt >= H_SS) && (x_nxt <= H_SE));
      vs           <= ~((y_nxt >= V_SS) && (y_nxt <= V_SE));
      blank        <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      frame_start  <= enter_frame;
      vblank_start <= enter_vblank;
    end
  end

  // Commit needs a full buffer and capture needs an empty one, so the two never collide.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_full <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      SpriteX   <= 10'(SPRITE_X0);
      SpriteY   <= 10'(SPRITE_Y0);
    end else if (enter_vblank && pend_full) begin
      SpriteX   <= pend_x;
      SpriteY   <= pend_y;
      pend_full <= 1'b0;
    end else if (upd_valid && !pend_full) begin
      pend_x    <= upd_x;
      pend_y    <= upd_y;
      pend_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a shrunk raster
// Expected values come from the edge count since reset release using div/mod arithmetic.

module tb_vga_timing_gen;

  localparam int HV  = 16;
  localparam int HSS = 18;
  localparam int HSE = 21;
  localparam int HT  = 24;
  localparam int VV  = 10;
  localparam int VSS = 12;
  localparam int VSE = 13;
  localparam int VT  = 15;
  localparam int X0  = 316;
  localparam int Y0  = 232;
  localparam int FR  = HT * VT;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       upd_valid = 1'b0;
  logic [9:0] upd_x = '0;
  logic [9:0] upd_y = '0;
  logic       upd_ready, pixel_clk, hs, vs, blank, sync, frame_start, vblank_start;
  logic [9:0] DrawX, DrawY, SpriteX, SpriteY;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .SPRITE_X0(X0), .SPRITE_Y0(Y0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .upd_valid(upd_valid), .upd_x(upd_x), .upd_y(upd_y),
    .upd_ready(upd_ready), .pixel_clk(pixel_clk), .hs(hs), .vs(vs), .blank(blank),
    .sync(sync), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
    .vblank_start(vblank_start), .SpriteX(SpriteX), .SpriteY(SpriteY)
  );

  always #5 Clk = ~Clk;

  int k;
  bit pend_m;
  int px_m, py_m, sx_m, sy_m;
  bit acc_last;
  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; pend_m = 0; sx_m = X0; sy_m = Y0; acc_last = 0;
  endtask

  task automatic check_all();
    int p, xm, ym;
    bit first;
    p = k / 2;
    xm = p % HT;
    ym = (p / HT) % VT;
    first = (k > 0) && (k % 2 == 0);
    chk("pixel_clk", 32'(pixel_clk), k % 2);
    chk("DrawX", 32'(DrawX), xm);
    chk("DrawY", 32'(DrawY), ym);
    chk("hs", 32'(hs), (xm >= HSS && xm <= HSE) ? 0 : 1);
    chk("vs", 32'(vs), (ym >= VSS && ym <= VSE) ? 0 : 1);
    chk("blank", 32'(blank), (xm < HV && ym < VV) ? 1 : 0);
    chk("sync", 32'(sync), 0);
    chk("frame_start", 32'(frame_start), (first && p % FR == 0) ? 1 : 0);
    chk("vblank_start", 32'(vblank_start), (first && p % FR == VV * HT) ? 1 : 0);
    chk("SpriteX", 32'(SpriteX), sx_m);
    chk("SpriteY", 32'(SpriteY), sy_m);
    chk("upd_ready", 32'(upd_ready), pend_m ? 0 : 1);
  endtask

  task automatic step();
    bit vb;
    bit rdy;
    @(posedge Clk);
    if (!Reset_n) begin
      model_reset();
    end else begin
      k++;
      acc_last = 0;
      vb = (k % 2 == 0) && ((k / 2) % FR == VV * HT);
      rdy = !pend_m;
      if (vb && pend_m) begin
        sx_m = px_m; sy_m = py_m; pend_m = 0;
      end else if (upd_valid && rdy) begin
        px_m = upd_x; py_m = upd_y; pend_m = 1; acc_last = 1;
      end
    end
    #1;
    check_all();
  endtask

  // which: 0 = vblank_start, 1 = frame_start, 2 = DrawY == y
  task automatic wait_for(input int which, input int y, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 3 * FR * 2 && !hit; i++) begin
      step();
      case (which)
        0:       hit = vblank_start;
        1:       hit = frame_start;
        default: hit = (32'(DrawY) == y);
      endcase
    end
    chk({"reach_", tag}, 32'(hit), 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'($urandom_range(0, 1));
      upd_x = 10'($urandom_range(0, 1023));
      upd_y = 10'($urandom_range(0, 1023));
      step();
    end
    upd_valid = 1'b0;
    Reset_n = 1'b1;
    step();
    step();
    chk("drawx_after_2nd_edge", 32'(DrawX), 1);

    wait_for(2, 3, "y3");
    upd_valid = 1'b1; upd_x = 10'd100; upd_y = 10'd50;
    step();
    chk("ready_falls_after_offer", 32'(upd_ready), 0);
    upd_x = 10'd200; upd_y = 10'd60;
    for (int i = 0; i < 40; i++) step();
    chk("sprite_x_held_before_vblank", 32'(SpriteX), X0);
    wait_for(0, 0, "vblank1");
    chk("commit_x_100", 32'(SpriteX), 100);
    chk("commit_y_50", 32'(SpriteY), 50);
    chk("ready_back_on_commit", 32'(upd_ready), 1);
    step();
    chk("second_offer_taken", 32'(upd_ready), 0);
    upd_valid = 1'b0;
    chk("second_not_yet_visible", 32'(SpriteX), 100);
    wait_for(0, 0, "vblank2");
    chk("commit_x_200", 32'(SpriteX), 200);
    chk("commit_y_60", 32'(SpriteY), 60);

    for (int i = 0; i < 1600; i++) begin
      if (!upd_valid && $urandom_range(0, 15) == 0) begin
        upd_valid = 1'b1;
        upd_x = 10'($urandom_range(0, 639));
        upd_y = 10'($urandom_range(0, 479));
      end
      step();
      if (acc_last) upd_valid = 1'b0;
    end
    upd_valid = 1'b0;

    wait_for(0, 0, "vblank_drain");
    wait_for(1, 0, "frame");
    wait_for(2, 6, "y6");
    upd_valid = 1'b1; upd_x = 10'd123; upd_y = 10'd45;
    step();
    upd_valid = 1'b0;
    chk("pending_before_reset", 32'(upd_ready), 0);
    for (int i = 0; i < 7; i++) step();
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < 3; i++) step();
    Reset_n = 1'b1;
    wait_for(0, 0, "vblank_after_reset");
    chk("no_commit_after_reset_x", 32'(SpriteX), X0);
    chk("no_commit_after_reset_y", 32'(SpriteY), Y0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Produces 640x480@60 Hz VGA timing from the 50 MHz system clock. Drives the DrawX/DrawY pixel coordinates, hs/vs/blank/sync, and pixel_clk into the color mapper and the VGA DAC. Also owns the sprite-position registers. The game logic hands off new positions through a valid/ready handshake, and the block commits them only at vertical-blank entry, so a sprite never tears mid-frame.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_SYNC_START, 656, first DrawX with hs low
- H_SYNC_END, 751, last DrawX with hs low
- H_TOTAL, 800, pixels per line
- V_VISIBLE, 480, visible lines
- V_SYNC_START, 490, first DrawY with vs low
- V_SYNC_END, 491, last DrawY with vs low
- V_TOTAL, 525, lines per frame
- SPRITE_X0, 316, SpriteX reset value
- SPRITE_Y0, 232, SpriteY reset value

Ports:
- Clk, in, 1, 50 MHz system clock; all state on rising edge
- Reset_n, in, 1, asynchronous, active-low reset
- upd_valid, in, 1, new sprite position offered
- upd_x, in, 10, offered X
- upd_y, in, 10, offered Y
- upd_ready, out, 1, block can accept an offer
- pixel_clk, out, 1, 25 MHz pixel clock/enable (toggle register)
- hs, out, 1, horizontal sync, active-low
- vs, out, 1, vertical sync, active-low
- blank, out, 1, active-low blank (1 = visible region)
- sync, out, 1, composite sync to DAC, constant 0
- DrawX, out, 10, current pixel column
- DrawY, out, 10, current line
- frame_start, out, 1, one-Clk pulse at start of each frame
- vblank_start, out, 1, one-Clk pulse at vertical-blank entry
- SpriteX, out, 10, committed sprite X
- SpriteY, out, 10, committed sprite Y

## Operation
- pixel_clk toggles every Clk. The pixel-advance enable pe is the cycle in which pixel_clk is 1 before the edge.
- DrawX/DrawY counters: on an edge with pe=1, DrawX increments.
  - At DrawX = H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
  - No other wraps; the counters never exceed the totals.
- Output decode matches the current counters on every Clk. Outputs are registered from the next counter values, so there is no skew vs DrawX/DrawY.
  - hs = 0 iff H_SYNC_START <= DrawX <= H_SYNC_END.
  - vs = 0 iff V_SYNC_START <= DrawY <= V_SYNC_END.
  - blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- frame_start is 1 for exactly the first Clk in which (DrawX, DrawY) = (0, 0) after a wrap. It is not asserted after reset.
- vblank_start is 1 for exactly the first Clk in which (DrawX, DrawY) = (0, V_VISIBLE).
- Sprite update, one-entry pending buffer:
  - upd_ready = ~pend_full.
  - Transfer occurs when upd_valid & upd_ready: upd_x/upd_y are captured and pend_full is set.
  - On the edge that moves counters into (0, V_VISIBLE): if pend_full, SpriteX/SpriteY take the pending values and pend_full clears.
  - Commit and capture cannot coincide, because ready is 0 while the buffer is full. An offer accepted on the commit edge waits for the next vblank.
  - upd_valid while ready=0 is held off. The offerer must keep upd_x/upd_y stable until the transfer.

## Timing
- Reset (async, Reset_n=0) values:
  - pixel_clk=0, DrawX=0, DrawY=0
  - hs=1, vs=1, blank=1, sync=0
  - frame_start=0, vblank_start=0
  - SpriteX=SPRITE_X0, SpriteY=SPRITE_Y0
  - pend_full=0, upd_ready=1
- After Reset_n deasserts:
  - Edge 1: pixel_clk 0→1.
  - Edge 2: DrawX 0→1.
  - Each pixel lasts 2 Clk.
- Period lengths:
  - Line: 1600 Clk.
  - hs low: 96 pixels = 192 Clk.
  - vs low: 2 lines = 3200 Clk.
  - Frame: 525*1600 = 840000 Clk.
- Sprite commit latency: SpriteX/Y change on the same edge at which DrawY becomes V_VISIBLE, which is also the first Clk of vblank_start. upd_ready returns to 1 on that edge.
- Reset mid-frame: all state returns to the reset values immediately, without waiting for a Clk. Any pending update is discarded.

## Test plan
- Reset: hold Reset_n=0 for 5 Clk with arbitrary inputs → every output equals its reset value. Release → DrawX=1 after the 2nd edge.
- Horizontal: measure from reset → hs falls when DrawX=656 and is low 192 Clk. The line repeats every 1600 Clk. blank=0 from DrawX=640 to 799.
- Vertical/frame: run 2 frames → vs low exactly 3200 Clk starting at DrawY=490. frame_start pulses once per 840000 Clk and is 1 Clk wide. vblank_start pulses at (0, 480).
- Sprite handshake: offer (100, 50) mid-frame → upd_ready falls the next Clk. SpriteX/Y stay at 316/232 until the vblank_start edge, then become 100/50 and upd_ready=1.
- Back-pressure: a second offer (200, 60) while full → not accepted and SpriteX/Y unchanged. It is accepted after the commit, then committed one frame later.
- Mid-frame reset: with an update pending, assert Reset_n=0 at DrawY=300 → immediate reset values and pending cleared. No commit occurs at the next vblank.
